// File: rtl/bp_update_pkg.sv
// Shared definitions for the branch-predictor update path: address width,
// reset polarity, update-queue geometry and the queued update record.
package bp_update_pkg;

    localparam int AddrLen     = 32;
    localparam logic ResetEnable = 1'b1;
    localparam int BPQDepth    = 4;
    localparam int BPQPtrLen   = 2;

    // Occupancy value that means "every slot holds an update".
    localparam logic [BPQPtrLen:0] BPQFullCount = (BPQPtrLen + 1)'(BPQDepth);

    // One pending predictor update: where, which way, and the real target.
    typedef struct packed {
        logic [AddrLen-1:0] pc;
        logic               jmp;
        logic [AddrLen-1:0] target;
    } bpq_entry_t;

    // Sequential fetch address after an instruction; wraps at the top of memory.
    function automatic logic [AddrLen-1:0] fallthrough(input logic [AddrLen-1:0] pc);
        return pc + AddrLen'(4);
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small in-order queue holding predictor updates until the predictor is free
// to take them. Storage is not reset; only pointers and occupancy are.
module bp_upd_fifo
    import bp_update_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  bpq_entry_t           din,
    output bpq_entry_t           dout,
    output logic                 empty,
    output logic                 full,
    output logic [BPQPtrLen:0]   count
);

    bpq_entry_t             r_mem [BPQDepth];
    logic [BPQPtrLen-1:0]   r_wr_ptr;
    logic [BPQPtrLen-1:0]   r_rd_ptr;
    logic [BPQPtrLen:0]     r_count;

    logic                   w_do_pop;
    logic                   w_do_push;

    // A pop only happens when something is queued; a push into a full queue
    // is still accepted when a pop frees the head slot in the same cycle.
    always_comb begin
        w_do_pop  = pop && (r_count != '0);
        w_do_push = push && ((r_count != BPQFullCount) || w_do_pop);
    end

    // Write the incoming entry into the tail slot.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Advance pointers and track occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == ResetEnable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Status and head-of-queue view, all derived from registered state.
    always_comb begin
        dout  = r_mem[r_rd_ptr];
        empty = (r_count == '0);
        full  = (r_count == BPQFullCount);
        count = r_count;
    end

endmodule

// File: rtl/bp_update.sv
// Branch resolution check: detects mispredicts from the EX stage, raises a
// one-cycle flush with the corrected fetch address, counts mispredicts and
// queues predictor updates that drain whenever the predictor is not held.
module bp_update
    import bp_update_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               br_valid,
    input  logic [AddrLen-1:0] br_pc,
    input  logic               br_pred_jmp,
    input  logic [AddrLen-1:0] br_pred_target,
    input  logic               br_jmp,
    input  logic [AddrLen-1:0] br_target,
    input  logic               upd_hold,
    output logic [AddrLen-1:0] addr_r,
    output logic               jmp_r,
    output logic [AddrLen-1:0] real_target,
    output logic               change_enable,
    output logic               flush,
    output logic [AddrLen-1:0] redirect_pc,
    output logic               queue_full,
    output logic [15:0]        mispredict_cnt
);

    logic                 w_mispredict;
    logic                 w_pop;
    bpq_entry_t           w_din;
    bpq_entry_t           w_dout;
    logic                 w_empty;
    logic                 w_full;
    logic [BPQPtrLen:0]   w_count_unused;

    logic                 r_flush;
    logic [AddrLen-1:0]   r_redirect_pc;
    logic [15:0]          r_mispredict_cnt;

    // A branch is mispredicted if the direction was wrong, or if it was
    // correctly predicted taken but to the wrong target.
    always_comb begin
        w_mispredict = br_valid &&
                       ((br_pred_jmp != br_jmp) ||
                        (br_jmp && (br_pred_target != br_target)));
        w_din.pc     = br_pc;
        w_din.jmp    = br_jmp;
        w_din.target = br_target;
    end

    // Flush pulse and the fetch address the front end must restart from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == ResetEnable) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= br_jmp ? br_target : fallthrough(br_pc);
            end
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == ResetEnable) begin
            r_mispredict_cnt <= '0;
        end else if (w_mispredict && (r_mispredict_cnt != 16'hFFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
    end

    bp_upd_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_mispredict),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count_unused)
    );

    // Drain the head entry to the predictor whenever it is not held off.
    always_comb begin
        w_pop          = !w_empty && !upd_hold;
        change_enable  = w_pop;
        addr_r         = w_dout.pc;
        jmp_r          = w_dout.jmp;
        real_target    = w_dout.target;
        flush          = r_flush;
        redirect_pc    = r_redirect_pc;
        queue_full     = w_full;
        mispredict_cnt = r_mispredict_cnt;
    end

endmodule
